// File: rtl/pwm_fade_ctrl_if.sv
// pwm_fade_ctrl_if: target/load and PWM/duty/status signals of the fade controller.
// Latency: none, this is just the bundle of wires.
// Backpressure: none; LOAD is a one-cycle strobe that is always accepted.
// Signals: target0/target1/load flow master->slave; pwm0/pwm1/duty0/duty1/busy/period_end flow slave->master.
interface pwm_fade_ctrl_if;
    logic [7:0] target0;
    logic [7:0] target1;
    logic       load;
    logic       pwm0;
    logic       pwm1;
    logic [7:0] duty0;
    logic [7:0] duty1;
    logic       busy;
    logic       period_end;

    modport master (
        output target0, target1, load,
        input  pwm0, pwm1, duty0, duty1, busy, period_end
    );

    modport slave (
        input  target0, target1, load,
        output pwm0, pwm1, duty0, duty1, busy, period_end
    );
endinterface

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: two-channel PWM whose applied duty fades toward host-loaded targets in fixed steps.
// Latency: counter to pin 1 cycle; LOAD/tick to BUSY 1 cycle; duty changes only on step ticks at a period wrap.
// Backpressure: none; LOAD is taken on any cycle and a newer target replaces the older one, even mid-fade.
// Ports: clk_i; rst_i (synchronous, active-high); bus = pwm_fade_ctrl_if.slave
//        (target0/target1/load in; pwm0/pwm1/duty0/duty1/busy/period_end out).
// Option macro PWM_FADE_GAMMA_EN: square-law mapping from linear duty to compared duty (duty outputs stay linear).
module pwm_fade_ctrl #(
    parameter int unsigned CNT_W      = 13,
    parameter int unsigned PERIOD_MAX = 32'h1FDF,
    parameter int unsigned STEP_DIV   = 16,
    parameter int unsigned STEP       = 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    pwm_fade_ctrl_if.slave bus
);
    typedef enum logic [1:0] { ST_IDLE, ST_UP, ST_DOWN } fade_st_e;

    localparam logic [CNT_W-1:0] PMAX     = CNT_W'(PERIOD_MAX);
    localparam logic [7:0]       DIV_LAST = 8'(STEP_DIV - 1);
    localparam logic [8:0]       STEP9    = 9'(STEP);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             period_end_q, period_end_d;
    logic [7:0]       presc_q, presc_d;
    logic             tick;
    logic [1:0][7:0]  target_q, target_d;
    logic [1:0][7:0]  duty_q, duty_d;
    logic [1:0][7:0]  eff;
    fade_st_e         st_q [2];
    fade_st_e         st_d [2];
    logic [1:0]       pwm_q, pwm_d;
    logic             busy_q, busy_d;
    logic [7:0]       cmp;
`ifdef PWM_FADE_GAMMA_EN
    logic [1:0][15:0] sq;
`endif

    // Saturating moves: 9-bit compares so the result never passes the target or wraps.
    function automatic logic [7:0] step_up(input logic [7:0] d, input logic [7:0] t);
        if (({1'b0, d} + STEP9) >= {1'b0, t}) return t;
        return d + STEP9[7:0];
    endfunction

    function automatic logic [7:0] step_down(input logic [7:0] d, input logic [7:0] t);
        if ({1'b0, d} <= ({1'b0, t} + STEP9)) return t;
        return d - STEP9[7:0];
    endfunction

    // Period counter, period-end pulse and step prescaler.
    always_comb begin
        cnt_d        = (cnt_q == PMAX) ? '0 : cnt_q + CNT_W'(1);
        period_end_d = (cnt_d == PMAX);
        // period_end_q is high exactly while cnt_q == PMAX, so a tick edge is also the wrap edge.
        tick         = period_end_q && (presc_q == DIV_LAST);
        presc_d      = presc_q;
        if (period_end_q) begin
            presc_d = tick ? 8'd0 : presc_q + 8'd1;
        end
        target_d = bus.load ? {bus.target1, bus.target0} : target_q;
    end

    // Per-channel fade FSM. The tick evaluates against target_q, so a LOAD landing on the
    // tick edge only takes effect from the following tick. Leaving IDLE moves on that same tick.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            st_d[c]   = st_q[c];
            duty_d[c] = duty_q[c];
            if (tick) begin
                unique case (st_q[c])
                    ST_IDLE: begin
                        if (target_q[c] > duty_q[c]) begin
                            st_d[c]   = ST_UP;
                            duty_d[c] = step_up(duty_q[c], target_q[c]);
                        end else if (target_q[c] < duty_q[c]) begin
                            st_d[c]   = ST_DOWN;
                            duty_d[c] = step_down(duty_q[c], target_q[c]);
                        end
                    end
                    ST_UP: begin
                        if (target_q[c] < duty_q[c]) begin
                            st_d[c]   = ST_DOWN;
                            duty_d[c] = step_down(duty_q[c], target_q[c]);
                        end else begin
                            duty_d[c] = step_up(duty_q[c], target_q[c]);
                        end
                    end
                    ST_DOWN: begin
                        if (target_q[c] > duty_q[c]) begin
                            st_d[c]   = ST_UP;
                            duty_d[c] = step_up(duty_q[c], target_q[c]);
                        end else begin
                            duty_d[c] = step_down(duty_q[c], target_q[c]);
                        end
                    end
                    default: st_d[c] = ST_IDLE;
                endcase
                if (duty_d[c] == target_q[c]) begin
                    st_d[c] = ST_IDLE;
                end
            end
        end
    end

    // Comparator on the top 8 counter bits; pin is registered (one cycle behind the counter).
    always_comb begin
        cmp = cnt_q[CNT_W-1 -: 8];
        for (int c = 0; c < 2; c++) begin
`ifdef PWM_FADE_GAMMA_EN
            sq[c]  = {8'd0, duty_q[c]} * {8'd0, duty_q[c]};
            eff[c] = (duty_q[c] == 8'hFF) ? 8'hFF : sq[c][15:8];
`else
            eff[c] = duty_q[c];
`endif
            pwm_d[c] = (cmp < eff[c]);
        end
        busy_d = (duty_d[0] != target_d[0]) || (duty_d[1] != target_d[1]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            period_end_q <= 1'b0;
            presc_q      <= '0;
            target_q     <= '0;
            duty_q       <= '0;
            pwm_q        <= '0;
            busy_q       <= 1'b0;
            st_q[0]      <= ST_IDLE;
            st_q[1]      <= ST_IDLE;
        end else begin
            cnt_q        <= cnt_d;
            period_end_q <= period_end_d;
            presc_q      <= presc_d;
            target_q     <= target_d;
            duty_q       <= duty_d;
            pwm_q        <= pwm_d;
            busy_q       <= busy_d;
            st_q[0]      <= st_d[0];
            st_q[1]      <= st_d[1];
        end
    end

    assign bus.pwm0       = pwm_q[0];
    assign bus.pwm1       = pwm_q[1];
    assign bus.duty0      = duty_q[0];
    assign bus.duty1      = duty_q[1];
    assign bus.busy       = busy_q;
    assign bus.period_end = period_end_q;
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb_pwm_fade_ctrl: bench for pwm_fade_ctrl with a shortened PWM period (9-bit counter) and nontrivial step size.
// Latency: n/a.
// Backpressure: n/a.
module tb_pwm_fade_ctrl;
    localparam int CNT_W    = 9;
    localparam int PMAX     = 509;          // cmp = cnt[8:1] tops out at 254, like the full-size default
    localparam int P        = PMAX + 1;
    localparam int STEP_DIV = 2;
    localparam int STEP     = 37;
    localparam int SH       = CNT_W - 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pwm_fade_ctrl_if bus ();

    pwm_fade_ctrl #(
        .CNT_W     (CNT_W),
        .PERIOD_MAX(PMAX),
        .STEP_DIV  (STEP_DIV),
        .STEP      (STEP)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    // Applied duty walks toward the last target seen before each tick by at most STEP;
    // a tick happens at every STEP_DIV-th period wrap since reset.
    int m_cnt = 0, m_wraps = 0;
    int m_tgt [2] = '{0, 0};
    int m_duty[2] = '{0, 0};
    int m_pwm [2] = '{0, 0};
    int m_busy = 0, m_pe = 0;
    int p_rst = 1, p_load = 0, p_t0 = 0, p_t1 = 0;

    function automatic int eff(input int d);
`ifdef PWM_FADE_GAMMA_EN
        return (d == 255) ? 255 : (d * d) / 256;
`else
        return d;
`endif
    endfunction

    function automatic int toward(input int d, input int t);
        if (t > d) return (d + STEP > t) ? t : d + STEP;
        if (t < d) return (d - STEP < t) ? t : d - STEP;
        return d;
    endfunction

    always @(negedge clk) begin
        bit tick;
        // advance the model over the rising edge that just happened
        if (p_rst != 0) begin
            m_cnt = 0; m_wraps = 0; m_busy = 0; m_pe = 0;
            for (int c = 0; c < 2; c++) begin
                m_tgt[c] = 0; m_duty[c] = 0; m_pwm[c] = 0;
            end
        end else begin
            tick = (m_cnt == PMAX) && (((m_wraps + 1) % STEP_DIV) == 0);
            for (int c = 0; c < 2; c++) begin
                m_pwm[c] = ((m_cnt >> SH) < eff(m_duty[c])) ? 1 : 0;
                if (tick) m_duty[c] = toward(m_duty[c], m_tgt[c]);
            end
            if (m_cnt == PMAX) m_wraps++;
            if (p_load != 0) begin
                m_tgt[0] = p_t0; m_tgt[1] = p_t1;
            end
            m_busy = (m_duty[0] != m_tgt[0] || m_duty[1] != m_tgt[1]) ? 1 : 0;
            m_cnt  = (m_cnt == PMAX) ? 0 : m_cnt + 1;
            m_pe   = (m_cnt == PMAX) ? 1 : 0;
        end
        chk("pwm0",       int'(bus.pwm0),       m_pwm[0]);
        chk("pwm1",       int'(bus.pwm1),       m_pwm[1]);
        chk("duty0",      int'(bus.duty0),      m_duty[0]);
        chk("duty1",      int'(bus.duty1),      m_duty[1]);
        chk("busy",       int'(bus.busy),       m_busy);
        chk("period_end", int'(bus.period_end), m_pe);
        // inputs now stable are the ones the next rising edge samples
        p_rst  = int'(rst);
        p_load = int'(bus.load);
        p_t0   = int'(bus.target0);
        p_t1   = int'(bus.target1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic load_t(input int a, input int b);
        @(posedge clk); #2;
        bus.target0 = 8'(a);
        bus.target1 = 8'(b);
        bus.load    = 1'b1;
        @(posedge clk); #2;
        bus.load    = 1'b0;
    endtask

    task automatic pulse_rst();
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Wait for the channel's duty to change, then compare the new value with a hand-computed one.
    task automatic next_duty(input int ch, input int exp, input string nm);
        int prev, cur, n;
        prev = (ch != 0) ? int'(bus.duty1) : int'(bus.duty0);
        cur  = prev;
        n    = 0;
        while (cur == prev && n < STEP_DIV * P + 20) begin
            @(negedge clk); #1;
            n++;
            cur = (ch != 0) ? int'(bus.duty1) : int'(bus.duty0);
        end
        chk(nm, cur, exp);
    endtask

    // Count high cycles of the pin over one full period, starting right after a duty change.
    task automatic pwm_high(input int ch, input int exp, input string nm);
        int hi;
        hi = 0;
        repeat (P) begin
            @(negedge clk); #1;
            hi += (ch != 0) ? int'(bus.pwm1) : int'(bus.pwm0);
        end
        chk(nm, hi, exp);
    endtask

    // Returns in the cycle before a tick edge's period-end cycle, so load_t lands exactly on the tick edge.
    task automatic wait_tick_coming();
        int n;
        int found;
        n = 0;
        found = 0;
        while (found == 0 && n < 3 * P) begin
            @(negedge clk); #1;
            n++;
            if (m_cnt == PMAX - 1 && ((m_wraps + 1) % STEP_DIV) == 0) found = 1;
        end
        chk("tick_sync_found", found, 1);
    endtask

    function automatic int rnd_tgt();
        int r;
        r = $urandom_range(0, 5);
        if (r == 0) return 0;
        if (r == 1) return 255;
        return $urandom_range(0, 255);
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        int n;
        bus.target0 = 8'd0;
        bus.target1 = 8'd0;
        bus.load    = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // reset state and first period end (cycle 0 = first cycle after the last reset edge)
        @(negedge clk); #1;
        chk("rst_duty0", int'(bus.duty0), 0);
        chk("rst_pwm0",  int'(bus.pwm0),  0);
        chk("rst_busy",  int'(bus.busy),  0);
        n = 0;
        while (bus.period_end !== 1'b1 && n < 2 * P) begin
            @(negedge clk); #1;
            n++;
        end
        chk("first_period_end_cycle", n, PMAX);

        // ramp up with saturation onto the target
        load_t(100, 0);
        next_duty(0, 37,  "up_a");
        next_duty(0, 74,  "up_b");
        next_duty(0, 100, "up_c");
        chk("up_busy_clear", int'(bus.busy), 0);
`ifdef PWM_FADE_GAMMA_EN
        pwm_high(0, 78, "pwm0_high_duty100");
`else
        pwm_high(0, 200, "pwm0_high_duty100");
`endif

        // ramp down, no wrap below zero
        load_t(0, 0);
        next_duty(0, 63, "dn_a");
        next_duty(0, 26, "dn_b");
        next_duty(0, 0,  "dn_c");
        pwm_high(0, 0, "pwm0_high_duty0");

        // channel 1 saturates at full on
        load_t(0, 255);
        next_duty(1, 37,  "sat_a");
        next_duty(1, 74,  "sat_b");
        next_duty(1, 111, "sat_c");
        next_duty(1, 148, "sat_d");
        next_duty(1, 185, "sat_e");
        next_duty(1, 222, "sat_f");
        next_duty(1, 255, "sat_g");
        pwm_high(1, P, "pwm1_high_duty255");

        // reversal with LOAD on the tick edge: that tick still uses the old target
        load_t(200, 255);
        next_duty(0, 37, "rev_a");
        next_duty(0, 74, "rev_b");
        wait_tick_coming();
        load_t(20, 255);
        @(negedge clk); #1;
        chk("rev_tick_old_target", int'(bus.duty0), 111);
        next_duty(0, 74, "rev_c");
        next_duty(0, 37, "rev_d");
        next_duty(0, 20, "rev_e");
        chk("rev_busy_clear", int'(bus.busy), 0);

        // random loads, tick-aligned loads and mid-fade resets against the model
        for (int i = 0; i < 30; i++) begin
            int r;
            repeat ($urandom_range(20, 1800)) @(posedge clk);
            r = $urandom_range(0, 9);
            if (r == 0) begin
                pulse_rst();
            end else if (r <= 2) begin
                wait_tick_coming();
                load_t(rnd_tgt(), rnd_tgt());
            end else begin
                load_t(rnd_tgt(), rnd_tgt());
            end
        end
        repeat (2000) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
